// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
//   Shared definitions for the program loader: word geometry, the loader FSM
//   state encoding and a helper that classifies states as "busy".
//   Imported by byte_packer and program_loader.
// -----------------------------------------------------------------------------
package loader_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        HDR   = 3'd2,
        LOAD  = 3'd3,
        WRITE = 3'd4,
        CHECK = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } state_t;

    // States during which a load is in progress.
    function automatic logic is_busy(input state_t s);
        return (s == CLEAR) || (s == HDR) || (s == LOAD) ||
               (s == WRITE) || (s == CHECK);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
//   Assembles 32-bit words from an 8-bit stream, most significant byte first.
//   The word being completed is presented combinationally together with a
//   one-cycle word_complete flag, so the owner can latch it on the same edge
//   that accepts the final byte.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset (clears the byte index)
//   clear          restart word alignment (index back to byte 0)
//   take           a byte is transferred on this edge
//   data[7:0]      the byte being transferred
//   word[31:0]     previously accepted bytes followed by the current byte
//   word_complete  take is high and the current byte is the 4th of a word
// -----------------------------------------------------------------------------
module byte_packer
    import loader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                take,
    input  logic [BYTE_W-1:0]   data,
    output logic [WORD_W-1:0]   word,
    output logic                word_complete
);

    // Only the three older bytes need storing; the fourth is the live input.
    logic [WORD_W-BYTE_W-1:0] shift;
    logic [1:0]               index;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            index <= 2'd0;
        end else if (take) begin
            index <= index + 2'd1;  // wraps 3 -> 0 at word completion
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            shift <= {shift[WORD_W-2*BYTE_W-1:0], data};
        end
    end

    assign word          = {shift, data};
    assign word_complete = take && (index == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//   Write-side initiator for the instruction memory load port. After a start
//   pulse it clears the memory, reads a header word N from the host byte
//   stream, then writes N payload words to consecutive addresses starting at
//   BASE_ADDR and finally signals load_done (or load_error on a bad header).
//   All outputs are registered: each is derived from the next state and
//   captured on the same edge as the state itself.
//
//   Optional feature (macro PROGRAM_LOADER_CHECKSUM_EN): a 32-bit wrap-around
//   sum of the payload words is kept and a trailer word is read in CHECK; a
//   matching trailer ends in DONE, anything else in ERR. Without the macro
//   CHECK is a single pass-through cycle and there is no sum register.
//
// Parameters
//   DEPTH      instruction words in memory (upper bound for N)
//   BASE_ADDR  write_address used for payload word 0
//
// Ports
//   clk                system clock, rising edge
//   reset              synchronous, active-high reset
//   start              begins a load; honoured in IDLE, DONE or ERR only
//   byte_valid         host byte present
//   byte_data[7:0]     host byte
//   byte_ready         loader accepts a byte (transfer = valid && ready)
//   instruction_reset  memory clear strobe, one cycle per load
//   write_signal       memory write strobe, one cycle per payload word
//   instruction_write  word to write (held between strobes)
//   write_address      word address (held between strobes)
//   busy               load in progress
//   load_done          program loaded; core may leave reset
//   load_error         load aborted
// -----------------------------------------------------------------------------
module program_loader
    import loader_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'd0
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        instruction_reset,
    output logic        write_signal,
    output logic [31:0] instruction_write,
    output logic [31:0] write_address,
    output logic        busy,
    output logic        load_done,
    output logic        load_error
);

    // Counter must be able to reach DEPTH itself, not just DEPTH-1.
    localparam int CNT_W = $clog2(DEPTH + 1);

    state_t              state;
    state_t              next_state;
    logic [WORD_W-1:0]   word_count;    // N from the header
    logic [CNT_W-1:0]    word_cnt;      // payload words written so far
    logic [WORD_W-1:0]   cnt_plus_one;

    logic                take;
    logic [WORD_W-1:0]   packed_word;
    logic                word_complete;

    // Next-cycle values of the registered control outputs.
    logic                ready_nxt;
    logic                clear_nxt;
    logic                write_nxt;
    logic                busy_nxt;
    logic                done_nxt;
    logic                error_nxt;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0]   sum;
`endif

    assign take         = byte_valid && byte_ready;
    assign cnt_plus_one = 32'(word_cnt) + 32'd1;

    byte_packer u_packer (
        .clk           (clk),
        .reset         (reset),
        .clear         (state == CLEAR),
        .take          (take),
        .data          (byte_data),
        .word          (packed_word),
        .word_complete (word_complete)
    );

    // Next state and next-cycle output values.
    always_comb begin
        next_state = state;
        ready_nxt  = 1'b0;
        clear_nxt  = 1'b0;
        write_nxt  = 1'b0;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
        error_nxt  = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) next_state = CLEAR;
            end
            CLEAR: begin
                next_state = HDR;
            end
            HDR: begin
                if (word_complete) begin
                    if (packed_word > 32'(DEPTH)) begin
                        next_state = ERR;
                    end else if (packed_word == '0) begin
                        next_state = CHECK;
                    end else begin
                        next_state = LOAD;
                    end
                end
            end
            LOAD: begin
                if (word_complete) next_state = WRITE;
            end
            WRITE: begin
                if (cnt_plus_one == word_count) begin
                    next_state = CHECK;
                end else begin
                    next_state = LOAD;
                end
            end
            CHECK: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                if (word_complete) begin
                    next_state = (packed_word == sum) ? DONE : ERR;
                end
`else
                next_state = DONE;
`endif
            end
            DONE: begin
                if (start) next_state = CLEAR;
            end
            ERR: begin
                if (start) next_state = CLEAR;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ready_nxt = (next_state == HDR) || (next_state == LOAD) ||
                    (next_state == CHECK);
`else
        ready_nxt = (next_state == HDR) || (next_state == LOAD);
`endif
        clear_nxt = (next_state == CLEAR);
        write_nxt = (next_state == WRITE);
        busy_nxt  = is_busy(next_state);
        done_nxt  = (next_state == DONE);
        error_nxt = (next_state == ERR);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            word_count        <= '0;
            word_cnt          <= '0;
            byte_ready        <= 1'b0;
            instruction_reset <= 1'b0;
            write_signal      <= 1'b0;
            instruction_write <= '0;
            write_address     <= '0;
            busy              <= 1'b0;
            load_done         <= 1'b0;
            load_error        <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum               <= '0;
`endif
        end else begin
            state             <= next_state;
            byte_ready        <= ready_nxt;
            instruction_reset <= clear_nxt;
            write_signal      <= write_nxt;
            busy              <= busy_nxt;
            load_done         <= done_nxt;
            load_error        <= error_nxt;

            if (state == CLEAR) begin
                word_count <= '0;
                word_cnt   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                sum        <= '0;
`endif
            end

            if ((state == HDR) && word_complete) begin
                word_count <= packed_word;
            end

            // Word and address are captured as the strobe is raised so they
            // are stable for the whole WRITE cycle and held afterwards.
            if ((state == LOAD) && word_complete) begin
                instruction_write <= packed_word;
                write_address     <= BASE_ADDR + 32'(word_cnt);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                sum               <= sum + packed_word;
`endif
            end

            if (state == WRITE) begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        instruction_reset;
    logic        write_signal;
    logic [31:0] instruction_write;
    logic [31:0] write_address;
    logic        busy;
    logic        load_done;
    logic        load_error;

    always #5 clk = ~clk;

    program_loader #(.DEPTH(256), .BASE_ADDR(32'd0)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .byte_valid        (byte_valid),
        .byte_data         (byte_data),
        .byte_ready        (byte_ready),
        .instruction_reset (instruction_reset),
        .write_signal      (write_signal),
        .instruction_write (instruction_write),
        .write_address     (write_address),
        .busy              (busy),
        .load_done         (load_done),
        .load_error        (load_error)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  pass_cnt  = 0;
    int  total_cnt = 0;
    int  ir_cnt    = 0;
    int  wr_cnt    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] addr, input logic [31:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every write strobe is matched against the queue.
    always @(negedge clk) begin
        wr_t e;
        if (instruction_reset) ir_cnt++;
        if (write_signal) begin
            wr_cnt++;
            check("strobe_exclusive", {30'd0, byte_ready, instruction_reset}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", write_address, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", write_address, e.addr);
                check("wr_data", instruction_write, e.data);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer one byte until accepted; optional idle cycle afterwards.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        forever begin
            @(negedge clk);
            if (byte_ready) break;
            n++;
            if (n > 100) break;
        end
        if (n > 100) begin
            check("byte_accept_timeout", 32'd0, 32'd1);
            byte_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            byte_valid = 1'b0;
            if (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        logic [31:0] v;
        v = w;
        for (int i = 3; i >= 0; i--) begin
            send_byte(v[i*8 +: 8], gap);
        end
    endtask

    task automatic send_trailer(input logic [31:0] w, input bit gap);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_word(w, gap);
`else
        if (gap && (w == 32'hFFFF_FFFF)) @(posedge clk);  // no trailer without checksum
`endif
    endtask

    // Wait (bounded) for load_done (which==0) or load_error (which==1).
    task automatic wait_flag(input string name, input int which, input int limit);
        logic f;
        f = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            f = (which == 0) ? load_done : load_error;
            if (f) break;
        end
        check(name, {31'd0, f}, 32'd1);
    endtask

    initial begin
        int base_ir;
        int base_wr;
        int lat;

        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_instr_reset", {31'd0, instruction_reset}, 32'd0);
        check("rst_write_signal", {31'd0, write_signal}, 32'd0);
        check("rst_instr_write", instruction_write, 32'd0);
        check("rst_write_addr", write_address, 32'd0);
        check("rst_done", {31'd0, load_done}, 32'd0);
        check("rst_error", {31'd0, load_error}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Two-word load.
        base_ir = ir_cnt;
        base_wr = wr_cnt;
        push_exp(32'd0, 32'h1122_3344);
        push_exp(32'd1, 32'hAABB_CCDD);
        pulse_start();
        @(negedge clk);
        check("t1_busy", {31'd0, busy}, 32'd1);
        send_word(32'h0000_0002, 1'b0);
        send_word(32'h1122_3344, 1'b0);
        send_word(32'hAABB_CCDD, 1'b0);
        send_trailer(32'hBBDE_0021, 1'b0);
        wait_flag("t1_done", 0, 20);
        check("t1_clear_pulses", 32'(ir_cnt - base_ir), 32'd1);
        check("t1_writes", 32'(wr_cnt - base_wr), 32'd2);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t1_not_busy", {31'd0, busy}, 32'd0);

        // Header N=0: no writes, done shortly after the header.
        base_ir = ir_cnt;
        base_wr = wr_cnt;
        pulse_start();
        check("t2_done_drops", {31'd0, load_done}, 32'd0);
        send_word(32'h0000_0000, 1'b0);
        send_trailer(32'h0000_0000, 1'b0);
        lat = 0;
        while ((lat < 3) && !load_done) begin
            @(negedge clk);
            lat++;
        end
        check("t2_done_within_3", {31'd0, load_done}, 32'd1);
        check("t2_writes", 32'(wr_cnt - base_wr), 32'd0);
        check("t2_clear_pulses", 32'(ir_cnt - base_ir), 32'd1);

        // Header N=257 exceeds DEPTH.
        base_wr = wr_cnt;
        pulse_start();
        send_word(32'h0000_0101, 1'b0);
        wait_flag("t3_error", 1, 5);
        check("t3_ready_low", {31'd0, byte_ready}, 32'd0);
        check("t3_not_busy", {31'd0, busy}, 32'd0);
        check("t3_writes", 32'(wr_cnt - base_wr), 32'd0);
        repeat (3) @(negedge clk);
        check("t3_error_held", {31'd0, load_error}, 32'd1);
        base_ir = ir_cnt;
        push_exp(32'd0, 32'hDEAD_BEEF);
        pulse_start();
        check("t3_error_drops", {31'd0, load_error}, 32'd0);
        send_word(32'h0000_0001, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b0);
        send_trailer(32'hDEAD_BEEF, 1'b0);
        wait_flag("t3_restart_done", 0, 20);
        check("t3_clear_pulses", 32'(ir_cnt - base_ir), 32'd1);
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // byte_valid toggling; start while busy must be ignored.
        base_ir = ir_cnt;
        base_wr = wr_cnt;
        push_exp(32'd0, 32'h0102_0304);
        push_exp(32'd1, 32'hA0B0_C0D0);
        pulse_start();
        send_word(32'h0000_0002, 1'b1);
        send_word(32'h0102_0304, 1'b1);
        pulse_start();
        send_word(32'hA0B0_C0D0, 1'b1);
        send_trailer(32'hA1B2_C3D4, 1'b1);
        wait_flag("t4_done", 0, 20);
        check("t4_clear_pulses", 32'(ir_cnt - base_ir), 32'd1);
        check("t4_writes", 32'(wr_cnt - base_wr), 32'd2);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset after 5 payload bytes, then a fresh load from BASE_ADDR.
        push_exp(32'd0, 32'hCAFE_BABE);
        pulse_start();
        send_word(32'h0000_0003, 1'b0);
        send_word(32'hCAFE_BABE, 1'b0);
        send_byte(8'h55, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("t5_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_write_signal", {31'd0, write_signal}, 32'd0);
        check("t5_instr_reset", {31'd0, instruction_reset}, 32'd0);
        check("t5_instr_write", instruction_write, 32'd0);
        check("t5_write_addr", write_address, 32'd0);
        check("t5_done", {31'd0, load_done}, 32'd0);
        check("t5_error", {31'd0, load_error}, 32'd0);
        reset = 1'b0;
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
        push_exp(32'd0, 32'h1234_5678);
        push_exp(32'd1, 32'h9ABC_DEF0);
        pulse_start();
        send_word(32'h0000_0002, 1'b0);
        send_word(32'h1234_5678, 1'b0);
        send_word(32'h9ABC_DEF0, 1'b0);
        send_trailer(32'hACF1_3568, 1'b0);
        wait_flag("t5_fresh_done", 0, 20);
        check("t5_fresh_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Checksum: 1 + 0xFFFFFFFF wraps to 0.
        push_exp(32'd0, 32'h0000_0001);
        push_exp(32'd1, 32'hFFFF_FFFF);
        pulse_start();
        send_word(32'h0000_0002, 1'b0);
        send_word(32'h0000_0001, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b0);
        send_word(32'h0000_0000, 1'b0);
        wait_flag("t6_sum_ok_done", 0, 5);
        check("t6_no_error", {31'd0, load_error}, 32'd0);

        push_exp(32'd0, 32'h0000_0001);
        push_exp(32'd1, 32'hFFFF_FFFF);
        pulse_start();
        send_word(32'h0000_0002, 1'b0);
        send_word(32'h0000_0001, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b0);
        send_word(32'h0000_0001, 1'b0);
        wait_flag("t7_sum_bad_error", 1, 5);
        check("t7_no_done", {31'd0, load_done}, 32'd0);
        check("t7_queue_empty", 32'(exp_q.size()), 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
